// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;

   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      HDR_WAIT_HI  = 3'd1,
      HDR_WAIT_LO  = 3'd2,
      DATA_WAIT_HI = 3'd3,
      DATA_WAIT_LO = 3'd4
   } arb_state_e;

   // Value of the top bit of every header byte; the requester ID fills the low bits.
   localparam logic HDR_MARKER = 1'b1;

   localparam int TMO_W = 4;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester bus plus transmitter pins shared by the arbiter and its environment.
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8
);
   localparam int IDW = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_ready;
   logic [DATA_WIDTH-1:0]         tx_data;
   logic                          tx_en;
   logic                          tx_busy;
   logic [IDW-1:0]                grant_id;
   logic                          active;
   logic                          timeout_err;

   modport master (
      input  req_valid, req_data, tx_busy,
      output req_ready, tx_data, tx_en, grant_id, active, timeout_err
   );

   modport slave (
      output req_valid, req_data, tx_busy,
      input  req_ready, tx_data, tx_en, grant_id, active, timeout_err
   );
endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin winner search: first valid index at or after ptr, cyclically.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   localparam int IDW    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [IDW-1:0]     ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDW-1:0]     idx,
   output logic               any_valid
);
   int   cand_s;
   logic found_s;

   // Scan candidates in priority order starting at the pointer.
   always_comb begin
      found_s = 1'b0;
      idx     = '0;
      cand_s  = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand_s  = (int'(ptr) + k) % NUM_REQ;
         idx     = (valid[cand_s] && !found_s) ? IDW'(cand_s) : idx;
         found_s = found_s | valid[cand_s];
      end
      any_valid  = found_s;
      grant      = '0;
      grant[idx] = found_s;
   end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter; each accepted byte goes out as
// an optional requester-ID header followed by the payload byte.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ       = 4,
   parameter int DATA_WIDTH    = 8,
   parameter int HEADER_EN     = 1,
   parameter int START_TIMEOUT = 15
) (
   input logic               clk,
   input logic               rst,
   uart_tx_arbiter_if.master bus
);
   localparam int IDW = $clog2(NUM_REQ);

   arb_state_e            state_r, state_nxt_s;
   logic [IDW-1:0]        ptr_r, ptr_nxt_s, win_idx_s, grant_id_r, grant_id_nxt_s;
   logic [NUM_REQ-1:0]    win_oh_s, req_ready_r, req_ready_nxt_s;
   logic                  any_valid_s;
   logic [DATA_WIDTH-1:0] win_data_s, header_s, payload_r, payload_nxt_s;
   logic [DATA_WIDTH-1:0] tx_data_r, tx_data_nxt_s;
   logic [TMO_W-1:0]      cnt_r, cnt_nxt_s;
   logic                  tx_en_r, tx_en_nxt_s, active_r, active_nxt_s, err_r, err_nxt_s;
   logic                  start_s, wait_hi_s, tmo_s, hdr_send_s, frame_end_s;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .valid     (bus.req_valid),
      .ptr       (ptr_r),
      .grant     (win_oh_s),
      .idx       (win_idx_s),
      .any_valid (any_valid_s)
   );

   assign win_data_s = bus.req_data[win_idx_s*DATA_WIDTH +: DATA_WIDTH];
   assign start_s    = (state_r == IDLE) && any_valid_s && !bus.tx_busy;
   assign wait_hi_s  = (state_r == HDR_WAIT_HI) || (state_r == DATA_WAIT_HI);
   // A start timeout is handled exactly as if busy had risen and already fallen.
   assign tmo_s       = wait_hi_s && !bus.tx_busy && (cnt_r == TMO_W'(START_TIMEOUT));
   assign hdr_send_s  = ((state_r == HDR_WAIT_HI) && tmo_s) || ((state_r == HDR_WAIT_LO) && !bus.tx_busy);
   assign frame_end_s = ((state_r == DATA_WAIT_HI) && tmo_s) || ((state_r == DATA_WAIT_LO) && !bus.tx_busy);

   // Header byte for the current winner.
   always_comb begin
      header_s                 = '0;
      header_s[DATA_WIDTH-1]   = HDR_MARKER;
      header_s[IDW-1:0]        = win_idx_s;
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_r <= IDLE;
      else     state_r <= state_nxt_s;
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (start_s) state_nxt_s = (HEADER_EN != 32'sd0) ? HDR_WAIT_HI : DATA_WAIT_HI;
            else         state_nxt_s = IDLE;
         end
         HDR_WAIT_HI: begin
            if (bus.tx_busy) state_nxt_s = HDR_WAIT_LO;
            else if (tmo_s)  state_nxt_s = DATA_WAIT_HI;
            else             state_nxt_s = HDR_WAIT_HI;
         end
         HDR_WAIT_LO:  state_nxt_s = hdr_send_s ? DATA_WAIT_HI : HDR_WAIT_LO;
         DATA_WAIT_HI: begin
            if (bus.tx_busy) state_nxt_s = DATA_WAIT_LO;
            else if (tmo_s)  state_nxt_s = IDLE;
            else             state_nxt_s = DATA_WAIT_HI;
         end
         DATA_WAIT_LO: state_nxt_s = frame_end_s ? IDLE : DATA_WAIT_LO;
         default:      state_nxt_s = IDLE;
      endcase
   end

   // Next values of the registered outputs and datapath.
   always_comb begin
      req_ready_nxt_s = '0;
      tx_en_nxt_s     = 1'b0;
      tx_data_nxt_s   = tx_data_r;
      grant_id_nxt_s  = grant_id_r;
      active_nxt_s    = active_r;
      ptr_nxt_s       = ptr_r;
      payload_nxt_s   = payload_r;
      cnt_nxt_s       = cnt_r;
      err_nxt_s       = err_r | tmo_s;
      if (start_s) begin
         req_ready_nxt_s = win_oh_s;
         tx_en_nxt_s     = 1'b1;
         tx_data_nxt_s   = (HEADER_EN != 32'sd0) ? header_s : win_data_s;
         grant_id_nxt_s  = win_idx_s;
         active_nxt_s    = 1'b1;
         ptr_nxt_s       = (win_idx_s == IDW'(NUM_REQ - 1)) ? '0 : win_idx_s + IDW'(1'b1);
         payload_nxt_s   = win_data_s;
         cnt_nxt_s       = '0;
      end else if (hdr_send_s) begin
         tx_en_nxt_s   = 1'b1;
         tx_data_nxt_s = payload_r;
         cnt_nxt_s     = '0;
      end else if (frame_end_s) begin
         active_nxt_s = 1'b0;
      end else if (wait_hi_s && !bus.tx_busy) begin
         cnt_nxt_s = cnt_r + TMO_W'(1'b1);
      end else begin
         cnt_nxt_s = cnt_r;
      end
   end

   // Output and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_ready_r <= '0;
         tx_en_r     <= 1'b0;
         tx_data_r   <= '0;
         grant_id_r  <= '0;
         active_r    <= 1'b0;
         err_r       <= 1'b0;
         ptr_r       <= '0;
         payload_r   <= '0;
         cnt_r       <= '0;
      end else begin
         req_ready_r <= req_ready_nxt_s;
         tx_en_r     <= tx_en_nxt_s;
         tx_data_r   <= tx_data_nxt_s;
         grant_id_r  <= grant_id_nxt_s;
         active_r    <= active_nxt_s;
         err_r       <= err_nxt_s;
         ptr_r       <= ptr_nxt_s;
         payload_r   <= payload_nxt_s;
         cnt_r       <= cnt_nxt_s;
      end
   end

   assign bus.req_ready   = req_ready_r;
   assign bus.tx_en       = tx_en_r;
   assign bus.tx_data     = tx_data_r;
   assign bus.grant_id    = grant_id_r;
   assign bus.active      = active_r;
   assign bus.timeout_err = err_r;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench: one arbiter with headers (bus_h), one without (bus_r),
// each driving a simple transmitter model.
module tb_uart_tx_arbiter;
   localparam int NREQ = 4;
   localparam int DW   = 8;
   localparam int OW   = NREQ + DW + $clog2(NREQ) + 3;

   logic clk = 1'b0;
   logic rst = 1'b1;

   uart_tx_arbiter_if #(.NUM_REQ(NREQ), .DATA_WIDTH(DW)) bus_h ();
   uart_tx_arbiter_if #(.NUM_REQ(NREQ), .DATA_WIDTH(DW)) bus_r ();

   uart_tx_arbiter #(.NUM_REQ(NREQ), .DATA_WIDTH(DW), .HEADER_EN(1), .START_TIMEOUT(15))
      u_hdr (.clk(clk), .rst(rst), .bus(bus_h));
   uart_tx_arbiter #(.NUM_REQ(NREQ), .DATA_WIDTH(DW), .HEADER_EN(0), .START_TIMEOUT(15))
      u_raw (.clk(clk), .rst(rst), .bus(bus_r));

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   logic [DW-1:0] exp_h[$], obs_h[$], exp_r[$], obs_r[$];
   int rdy_h[NREQ];
   int rdy_r[NREQ];
   int ten_h, ten_r;
   bit multi_h, multi_r;
   int busy_len_h = 5, busy_len_r = 5, bcnt_h = 0, bcnt_r = 0;
   bit force_busy_h = 1'b0, dead_h = 1'b0;

   // Transmitter models: busy rises the cycle after tx_en and lasts busy_len cycles.
   always @(posedge clk) begin
      if (force_busy_h) begin
         bus_h.tx_busy <= 1'b1; bcnt_h <= 0;
      end else if (bus_h.tx_en && !dead_h) begin
         bus_h.tx_busy <= 1'b1; bcnt_h <= busy_len_h;
      end else if (bcnt_h > 1) bcnt_h <= bcnt_h - 1;
      else begin
         bus_h.tx_busy <= 1'b0; bcnt_h <= 0;
      end
   end

   always @(posedge clk) begin
      if (bus_r.tx_en) begin
         bus_r.tx_busy <= 1'b1; bcnt_r <= busy_len_r;
      end else if (bcnt_r > 1) bcnt_r <= bcnt_r - 1;
      else begin
         bus_r.tx_busy <= 1'b0; bcnt_r <= 0;
      end
   end

   function automatic logic [OW-1:0] outs(input bit sel);
      if (sel) return {bus_r.req_ready, bus_r.tx_data, bus_r.tx_en, bus_r.grant_id, bus_r.active, bus_r.timeout_err};
      else     return {bus_h.req_ready, bus_h.tx_data, bus_h.tx_en, bus_h.grant_id, bus_h.active, bus_h.timeout_err};
   endfunction

   // One cycle: log transmitted bytes and acceptances; requesters drop valid once accepted.
   task automatic tick();
      @(negedge clk);
      if (bus_h.tx_en) begin obs_h.push_back(bus_h.tx_data); ten_h++; end
      if (bus_r.tx_en) begin obs_r.push_back(bus_r.tx_data); ten_r++; end
      for (int i = 0; i < NREQ; i++) begin
         if (bus_h.req_ready[i]) begin rdy_h[i]++; bus_h.req_valid[i] = 1'b0; end
         if (bus_r.req_ready[i]) begin rdy_r[i]++; bus_r.req_valid[i] = 1'b0; end
      end
      if ($countones(bus_h.req_ready) > 1) multi_h = 1'b1;
      if ($countones(bus_r.req_ready) > 1) multi_r = 1'b1;
   endtask

   task automatic clear_logs();
      exp_h.delete(); obs_h.delete(); exp_r.delete(); obs_r.delete();
      for (int i = 0; i < NREQ; i++) begin rdy_h[i] = 0; rdy_r[i] = 0; end
      ten_h = 0; ten_r = 0; multi_h = 1'b0; multi_r = 1'b0;
   endtask

   task automatic run_idle(input bit sel, input int limit, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < limit && !ok; c++) begin
         tick();
         if (sel) ok = (bus_r.req_valid == '0) && !bus_r.active && !bus_r.tx_busy;
         else     ok = (bus_h.req_valid == '0) && !bus_h.active && !bus_h.tx_busy;
      end
   endtask

   task automatic do_reset();
      bus_h.req_valid = '0; bus_r.req_valid = '0;
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      clear_logs();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      n_checks++;
      if (outs(1'b0) !== '0) begin n_fail++; $display("FAIL reset_hdr_outputs: got %h, want 0", outs(1'b0)); end
      n_checks++;
      if (outs(1'b1) !== '0) begin n_fail++; $display("FAIL reset_raw_outputs: got %h, want 0", outs(1'b1)); end
      rst = 1'b0;
      repeat (2) tick();
      n_checks++;
      if (outs(1'b0) !== '0) begin n_fail++; $display("FAIL post_reset_outputs: got %h, want 0", outs(1'b0)); end
      clear_logs();
   endtask

   task automatic test_single();
      bit seen = 1'b0, done = 1'b0;
      logic busy_at_fall = 1'b1;
      int ten_at_fall = 0;
      logic [DW-1:0] e, o;
      busy_len_h = 20;
      clear_logs();
      bus_h.req_data[1*DW +: DW] = 8'h5A;
      bus_h.req_valid[1] = 1'b1;
      exp_h.push_back(8'h80 | 8'd1); exp_h.push_back(8'h5A);
      for (int c = 0; c < 200 && !done; c++) begin
         tick();
         if (bus_h.active) seen = 1'b1;
         else if (seen) begin done = 1'b1; busy_at_fall = bus_h.tx_busy; ten_at_fall = ten_h; end
      end
      n_checks++;
      if (!done) begin n_fail++; $display("FAIL single_active_fall: got no fall in 200 cycles, want fall"); end
      n_checks++;
      if (ten_at_fall != 2 || busy_at_fall !== 1'b0) begin
         n_fail++; $display("FAIL single_fall_timing: got tx_en=%0d busy=%b, want 2 and 0", ten_at_fall, busy_at_fall);
      end
      n_checks++;
      if (rdy_h[1] != 1 || rdy_h[0] + rdy_h[2] + rdy_h[3] != 0) begin
         n_fail++; $display("FAIL single_ready: got r1=%0d others=%0d, want 1 and 0", rdy_h[1], rdy_h[0] + rdy_h[2] + rdy_h[3]);
      end
      n_checks++;
      if (bus_h.grant_id !== 2'd1) begin n_fail++; $display("FAIL single_grant_id: got %0d, want 1", bus_h.grant_id); end
      while (exp_h.size() != 0) begin
         e = exp_h.pop_front();
         o = (obs_h.size() != 0) ? obs_h.pop_front() : {DW{1'bx}};
         n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL single_byte: got %h, want %h", o, e); end
      end
      n_checks++;
      if (obs_h.size() != 0) begin n_fail++; $display("FAIL single_extra: got %0d extra bytes, want 0", obs_h.size()); end
   endtask

   task automatic test_all_four();
      bit ok;
      logic [DW-1:0] e, o;
      do_reset();
      busy_len_h = 5;
      for (int i = 0; i < NREQ; i++) begin
         bus_h.req_data[i*DW +: DW] = 8'h10 + 8'(i);
         exp_h.push_back(8'h80 | 8'(i));
         exp_h.push_back(8'h10 + 8'(i));
      end
      bus_h.req_valid = 4'b1111;
      run_idle(1'b0, 600, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL all4_idle: got busy after 600 cycles, want idle"); end
      while (exp_h.size() != 0) begin
         e = exp_h.pop_front();
         o = (obs_h.size() != 0) ? obs_h.pop_front() : {DW{1'bx}};
         n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL all4_byte: got %h, want %h", o, e); end
      end
      for (int i = 0; i < NREQ; i++) begin
         n_checks++;
         if (rdy_h[i] != 1) begin n_fail++; $display("FAIL all4_ready_%0d: got %0d pulses, want 1", i, rdy_h[i]); end
      end
      n_checks++;
      if (multi_h) begin n_fail++; $display("FAIL all4_onehot: got multiple ready bits, want one-hot"); end
   endtask

   task automatic test_no_header();
      bit ok;
      logic [DW-1:0] e, o;
      busy_len_r = 5;
      clear_logs();
      bus_r.req_data[2*DW +: DW] = 8'h22;
      bus_r.req_data[3*DW +: DW] = 8'h33;
      exp_r.push_back(8'h22); exp_r.push_back(8'h33);
      bus_r.req_valid = 4'b1100;
      run_idle(1'b1, 300, ok);
      n_checks++;
      if (!ok || ten_r != 2) begin n_fail++; $display("FAIL nohdr_tx_en: got %0d strobes ok=%b, want 2", ten_r, ok); end
      while (exp_r.size() != 0) begin
         e = exp_r.pop_front();
         o = (obs_r.size() != 0) ? obs_r.pop_front() : {DW{1'bx}};
         n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL nohdr_byte: got %h, want %h", o, e); end
      end
   endtask

   task automatic test_busy_hold();
      bit ok;
      logic [DW-1:0] e, o;
      clear_logs();
      force_busy_h = 1'b1;
      repeat (2) tick();
      bus_h.req_data[0 +: DW] = 8'h44;
      bus_h.req_valid[0] = 1'b1;
      exp_h.push_back(8'h80); exp_h.push_back(8'h44);
      repeat (10) tick();
      n_checks++;
      if (rdy_h[0] != 0 || ten_h != 0) begin n_fail++; $display("FAIL hold_no_grant: got ready=%0d tx_en=%0d, want 0 0", rdy_h[0], ten_h); end
      force_busy_h = 1'b0;
      tick();
      n_checks++;
      if (bus_h.tx_busy !== 1'b0 || bus_h.req_ready !== 4'b0000) begin
         n_fail++; $display("FAIL hold_fall_cycle: got busy=%b ready=%b, want 0 0000", bus_h.tx_busy, bus_h.req_ready);
      end
      tick();
      n_checks++;
      if (bus_h.req_ready !== 4'b0001 || bus_h.tx_en !== 1'b1) begin
         n_fail++; $display("FAIL hold_grant_cycle: got ready=%b tx_en=%b, want 0001 1", bus_h.req_ready, bus_h.tx_en);
      end
      run_idle(1'b0, 300, ok);
      while (exp_h.size() != 0) begin
         e = exp_h.pop_front();
         o = (obs_h.size() != 0) ? obs_h.pop_front() : {DW{1'bx}};
         n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL hold_byte: got %h, want %h", o, e); end
      end
   endtask

   task automatic test_timeout();
      bit cap = 1'b0, done = 1'b0;
      int err_j = -1;
      logic [DW-1:0] e, o;
      clear_logs();
      dead_h = 1'b1;
      bus_h.req_data[2*DW +: DW] = 8'h66;
      bus_h.req_valid[2] = 1'b1;
      exp_h.push_back(8'h80 | 8'd2); exp_h.push_back(8'h66);
      for (int c = 0; c < 10 && !cap; c++) begin tick(); cap = (rdy_h[2] == 1); end
      n_checks++;
      if (!cap) begin n_fail++; $display("FAIL tmo_capture: got no ready in 10 cycles, want ready"); end
      for (int j = 1; j < 100 && !done; j++) begin
         tick();
         if (bus_h.timeout_err && err_j < 0) err_j = j;
         done = !bus_h.active;
      end
      n_checks++;
      if (err_j < 15 || err_j > 17) begin n_fail++; $display("FAIL tmo_err_time: got cycle %0d, want 15..17", err_j); end
      n_checks++;
      if (!done || ten_h != 2) begin n_fail++; $display("FAIL tmo_advance: got done=%b tx_en=%0d, want 1 2", done, ten_h); end
      while (exp_h.size() != 0) begin
         e = exp_h.pop_front();
         o = (obs_h.size() != 0) ? obs_h.pop_front() : {DW{1'bx}};
         n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL tmo_byte: got %h, want %h", o, e); end
      end
      repeat (5) tick();
      n_checks++;
      if (bus_h.timeout_err !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky: got %b, want 1", bus_h.timeout_err); end
      dead_h = 1'b0;
   endtask

   task automatic test_reset_mid();
      bit ok = 1'b0;
      logic [DW-1:0] e, o;
      do_reset();
      n_checks++;
      if (bus_h.timeout_err !== 1'b0) begin n_fail++; $display("FAIL mid_err_cleared: got %b, want 0", bus_h.timeout_err); end
      busy_len_h = 6;
      bus_h.req_data[1*DW +: DW] = 8'h77;
      bus_h.req_valid[1] = 1'b1;
      exp_h.push_back(8'h81); exp_h.push_back(8'h77);
      for (int c = 0; c < 100 && !ok; c++) begin tick(); ok = (ten_h == 2) && bus_h.tx_busy; end
      tick();
      n_checks++;
      if (!ok || bus_h.active !== 1'b1) begin n_fail++; $display("FAIL mid_reach_lo: got ok=%b active=%b, want 1 1", ok, bus_h.active); end
      while (exp_h.size() != 0) begin
         e = exp_h.pop_front();
         o = (obs_h.size() != 0) ? obs_h.pop_front() : {DW{1'bx}};
         n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL mid_byte: got %h, want %h", o, e); end
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if (outs(1'b0) !== '0) begin n_fail++; $display("FAIL mid_async_clear: got %h, want 0", outs(1'b0)); end
      for (int c = 0; c < 8; c++) begin
         tick();
         n_checks++;
         if (outs(1'b0) !== '0) begin n_fail++; $display("FAIL mid_in_reset: got %h, want 0", outs(1'b0)); end
      end
      rst = 1'b0;
      tick();
      n_checks++;
      if (outs(1'b0) !== '0 || ten_h != 2) begin n_fail++; $display("FAIL mid_after_release: got %h tx_en=%0d, want 0 2", outs(1'b0), ten_h); end
      bus_h.req_data[0 +: DW] = 8'h30;
      bus_h.req_data[3*DW +: DW] = 8'h33;
      exp_h.push_back(8'h80); exp_h.push_back(8'h30); exp_h.push_back(8'h83); exp_h.push_back(8'h33);
      bus_h.req_valid = 4'b1001;
      run_idle(1'b0, 300, ok);
      while (exp_h.size() != 0) begin
         e = exp_h.pop_front();
         o = (obs_h.size() != 0) ? obs_h.pop_front() : {DW{1'bx}};
         n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL mid_restart_byte: got %h, want %h", o, e); end
      end
   endtask

   initial begin
      bus_h.req_valid = '0; bus_h.req_data = '0;
      bus_r.req_valid = '0; bus_r.req_data = '0;
      test_reset();
      test_single();
      test_all_four();
      test_no_header();
      test_busy_hold();
      test_timeout();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got simulation still running, want finished");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter among NUM_REQ independent requesters. Arbitration is round-robin.
- Each granted byte goes out as a two-byte frame: a header byte carrying the requester ID, then the payload byte. The header can be disabled by parameter.
- Sits between the bus-side requesters and the transmitter's data_input/data_en/tx_busy pins.
- Sequences one byte at a time and never issues a new byte while the transmitter is busy.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- DATA_WIDTH, 8, byte width; must satisfy DATA_WIDTH >= $clog2(NUM_REQ)+1.
- HEADER_EN, 1, 1 = send the ID header before each payload byte; 0 = send the payload byte only.
- START_TIMEOUT, 15, maximum number of cycles to wait for tx_busy to rise after tx_en.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester valid. Held high with stable data until that requester's req_ready pulse.
- req_data  in  NUM_REQ*DATA_WIDTH  packed payloads; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  one-cycle, registered, one-hot acceptance pulse.
- tx_data  out  DATA_WIDTH  byte to the transmitter; held stable from the tx_en pulse until the frame byte completes.
- tx_en  out  1  one-cycle, registered transmit strobe.
- tx_busy  in  1  busy flag from the transmitter.
- grant_id  out  $clog2(NUM_REQ)  ID of the requester currently being served.
- active  out  1  high from capture until the last byte of the frame completes.
- timeout_err  out  1  sticky flag, set on a start timeout, cleared only by rst.

Behaviour:
- Reset values:
  - All outputs are 0.
  - Round-robin pointer is 0, so requester 0 has highest priority first.
  - State is IDLE.
  - Asserting rst mid-frame abandons the frame immediately; no further tx_en is issued.
- IDLE:
  - When any req_valid is high and tx_busy is low, pick winner g: the first valid index at or after the pointer, searching cyclically.
  - At that same edge, register the following:
    - capture req_data[g] into the holding register;
    - grant_id <= g;
    - req_ready[g] <= 1 for exactly one cycle;
    - active <= 1;
    - tx_en <= 1 for one cycle;
    - pointer <= (g+1) mod NUM_REQ.
  - tx_data gets the header when HEADER_EN=1, otherwise the payload.
  - The next state is HDR_WAIT_HI when HEADER_EN=1, otherwise DATA_WAIT_HI.
  - If tx_busy is high, IDLE waits and issues no grant.
- Header encoding: MSB = 1, low bits = grant_id, all other bits 0. For NUM_REQ=4, requester 2 gives header 8'h82.
- *_WAIT_HI:
  - Wait for tx_busy=1, then go to *_WAIT_LO.
  - A 4-bit counter, cleared at every tx_en, counts the cycles. If it reaches START_TIMEOUT with tx_busy still low:
    - set timeout_err;
    - treat the byte as sent;
    - proceed as if tx_busy had fallen.
- HDR_WAIT_LO: on tx_busy=0, drive tx_data <= payload and tx_en <= 1 (one cycle), then go to DATA_WAIT_HI.
- DATA_WAIT_LO: on tx_busy=0, active <= 0 and return to IDLE. The next grant can occur on the following edge, earliest one cycle after returning.
- Latency: tx_en is high in the cycle immediately after the capture edge. With an ideal transmitter, frame bytes are back-to-back, separated by 1 cycle after tx_busy falls.
- Requesters not granted keep req_valid high; they are served in round-robin order. No requester is starved: worst-case wait is NUM_REQ-1 frames.
- Once the IDLE edge has captured a request, that requester dropping req_valid has no effect on the frame.
- A simultaneous valid from every requester is served 0,1,2,3,0,... starting from the pointer.
- req_ready is never asserted outside the IDLE capture edge. At most one req_ready bit is high in any cycle.

Decomposition:
- Package uart_arb_pkg holds:
  - state enum: IDLE, HDR_WAIT_HI, HDR_WAIT_LO, DATA_WAIT_HI, DATA_WAIT_LO;
  - HDR_MARKER constant (the MSB-set pattern);
  - the timeout counter width.
- Sub-module rr_arbiter: combinational winner search from pointer and valid vector. Outputs are a one-hot grant, the encoded index and any_valid. The pointer register stays in the parent.

Test Plan:
- Single request: req_valid[1]=1, req_data=8'h5A, model busy lasting 20 cycles per byte. Required: req_ready[1] pulses once, tx_en fires twice, bytes are 8'h81 then 8'h5A, and active falls after the second busy fall.
- All four requesters valid at once with payloads 8'h10..8'h13. Required: frames in order 0,1,2,3; headers 8'h80..8'h83; each req_ready pulses exactly once.
- HEADER_EN=0, requesters 2 and 3 valid. Required: only payload bytes are sent, in order 2 then 3, one tx_en per frame.
- tx_busy held high at the moment a request arrives. Required: no req_ready and no tx_en until tx_busy falls; grant occurs 1 cycle later.
- Transmitter never raises tx_busy. Required: timeout_err=1 after 15 cycles, the FSM advances to the payload and then to IDLE, and the error flag stays set.
- Assert rst during DATA_WAIT_LO. Required: all outputs 0 while reset is applied and after release; the pointer restarts at requester 0 on the next request.
